// File: rtl/light_tick_gen.sv
// Speed-controlled step generator for an LED shifter: three debounced push-buttons
// pick one of four step rates (or pause), and a free-running counter emits step pulses.
module light_tick_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_pause,
  output logic       step,
  output logic [1:0] speed_level,
  output logic       paused
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Key index: 0 = up, 1 = down, 2 = pause
  logic [2:0] keys_raw;
  logic [2:0] press;

  assign keys_raw = {key_pause, key_down, key_up};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            stable_prev_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q       <= 1'b0;
        sync2_q       <= 1'b0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
        press_q       <= 1'b0;
        db_cnt_q      <= '0;
      end else begin
        sync1_q       <= keys_raw[gi];
        sync2_q       <= sync1_q;
        stable_q      <= stable_d;
        stable_prev_q <= stable_q;
        press_q       <= stable_q & ~stable_prev_q;
        db_cnt_q      <= db_cnt_d;
      end
    end

    assign press[gi] = press_q;
  end

  logic             up_p;
  logic             dn_p;
  logic             pz_p;
  logic [1:0]       level_q;
  logic [1:0]       level_d;
  logic             paused_q;
  logic             paused_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] term;
  logic             level_chg;
  logic             at_term;

  assign up_p = press[0];
  assign dn_p = press[1];
  assign pz_p = press[2];

  always_comb begin
    level_d = level_q;
    if (up_p && !dn_p && level_q != 2'd3) begin
      level_d = level_q + 2'd1;
    end else if (dn_p && !up_p && level_q != 2'd0) begin
      level_d = level_q - 2'd1;
    end
    paused_d  = paused_q ^ pz_p;
    level_chg = (level_d != level_q);

    // Each speed level halves the period: terminal is 2^(CNT_W-level)-1.
    term    = {CNT_W{1'b1}} >> level_q;
    at_term = (cnt_q == term);
    step    = !paused_q && !level_chg && at_term;

    cnt_d = cnt_q;
    if (level_chg) begin
      cnt_d = '0;
    end else if (!paused_q) begin
      cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q  <= 2'd0;
      paused_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      level_q  <= level_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
    end
  end

  assign speed_level = level_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_light_tick_gen.sv
// Bench for light_tick_gen: directed table plus hand sequences, then random keys
// compared every cycle against a sample-history reference model.
module tb_light_tick_gen;

  localparam int DEB = 4;
  localparam int CW  = 6;
  localparam int HW  = DEB + 2;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       key_up    = 1'b0;
  logic       key_down  = 1'b0;
  logic       key_pause = 1'b0;
  logic       step;
  logic [1:0] speed_level;
  logic       paused;

  int checks   = 0;
  int failures = 0;

  light_tick_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_pause  (key_pause),
    .step       (step),
    .speed_level(speed_level),
    .paused     (paused)
  );

  always #5 clock = ~clock;

  // Reference model: a key level is accepted once the last DEB raw samples seen
  // through the two-stage synchronizer all disagree with the accepted level;
  // a 0->1 acceptance acts on speed/pause two edges later.
  logic [2:0]    keys_now;
  logic [HW-1:0] m_hist [3];
  logic          m_stable [3];
  logic [1:0]    m_pipe [3];
  int            m_level;
  logic          m_paused;
  int            m_elapsed;

  assign keys_now = {key_pause, key_down, key_up};

  function automatic logic m_flip(input logic [HW-1:0] h, input logic st);
    for (int i = 1; i <= DEB; i++) begin
      if (h[i] == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int m_next_level(input int lvl, input logic up, input logic dn);
    int n;
    n = lvl + int'(up) - int'(dn);
    if (n < 0) n = 0;
    if (n > 3) n = 3;
    return n;
  endfunction

  function automatic int m_period(input int lvl);
    return 1 << (CW - lvl);
  endfunction

  function automatic logic exp_step();
    int nl;
    nl = m_next_level(m_level, m_pipe[0][1], m_pipe[1][1]);
    return !m_paused && (nl == m_level) && (m_elapsed == m_period(m_level) - 1);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_hist[k]   <= '0;
        m_stable[k] <= 1'b0;
        m_pipe[k]   <= 2'b00;
      end
      m_level   <= 0;
      m_paused  <= 1'b0;
      m_elapsed <= 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_hist[k] <= {m_hist[k][HW-2:0], keys_now[k]};
        if (m_flip(m_hist[k], m_stable[k])) m_stable[k] <= ~m_stable[k];
        m_pipe[k] <= {m_pipe[k][0], m_flip(m_hist[k], m_stable[k]) & ~m_stable[k]};
      end
      m_level  <= m_next_level(m_level, m_pipe[0][1], m_pipe[1][1]);
      m_paused <= m_paused ^ m_pipe[2][1];
      if (m_next_level(m_level, m_pipe[0][1], m_pipe[1][1]) != m_level) m_elapsed <= 0;
      else if (m_paused) m_elapsed <= m_elapsed;
      else if (m_elapsed == m_period(m_level) - 1) m_elapsed <= 0;
      else m_elapsed <= m_elapsed + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check("cyc_step", int'(step), int'(exp_step()));
    check("cyc_level", int'(speed_level), m_level);
    check("cyc_paused", int'(paused), int'(m_paused));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {key_pause, key_down, key_up} = 3'b000;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic wait_step(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < max);
    if (!step) n = -1;
  endtask

  task automatic count_steps(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (step) cnt++;
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold, output int chg_at);
    logic [1:0] lv0;
    logic       p0;
    lv0    = speed_level;
    p0     = paused;
    chg_at = -1;
    {key_pause, key_down, key_up} = mask;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (chg_at < 0 && (speed_level != lv0 || paused != p0)) chg_at = i;
    end
    {key_pause, key_down, key_up} = 3'b000;
  endtask

  typedef struct {
    logic [2:0] keys;
    int         exp_level;
    int         exp_paused;
    int         exp_chg;
    int         exp_period;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    int chg;
    int cnt;

    // keys = {pause, down, up}; exp_chg is the tick of the visible change, -1 if none
    tbl[0]  = '{3'b001, 1, 0, DEB + 4, 32};
    tbl[1]  = '{3'b001, 2, 0, DEB + 4, 16};
    tbl[2]  = '{3'b001, 3, 0, DEB + 4, 8};
    tbl[3]  = '{3'b001, 3, 0, -1,      8};
    tbl[4]  = '{3'b010, 2, 0, DEB + 4, 16};
    tbl[5]  = '{3'b010, 1, 0, DEB + 4, 32};
    tbl[6]  = '{3'b100, 1, 1, DEB + 4, 0};
    tbl[7]  = '{3'b100, 1, 0, DEB + 4, 32};
    tbl[8]  = '{3'b011, 1, 0, -1,      32};
    tbl[9]  = '{3'b101, 2, 1, DEB + 4, 0};
    tbl[10] = '{3'b110, 1, 0, DEB + 4, 32};
    tbl[11] = '{3'b010, 0, 0, DEB + 4, 64};
    tbl[12] = '{3'b010, 0, 0, -1,      64};

    // Reset release: counter starts at 0, so the first step lands on edge 63
    do_reset();
    check("rst_level", int'(speed_level), 0);
    check("rst_paused", int'(paused), 0);
    wait_step(200, n);
    check("first_step_after_reset", n, 63);
    wait_step(200, n);
    check("period_l0", n, 64);

    // Short glitch is ignored; a held key acts DEB+3 edges after its first sample
    key_up = 1'b1;
    idle(3);
    key_up = 1'b0;
    idle(12);
    check("glitch_level", int'(speed_level), 0);
    press(3'b001, 20, chg);
    check("up_latency", chg, DEB + 4);
    check("up_level", int'(speed_level), 1);
    wait_step(200, n);
    check("first_step_l1", n, 31 - (20 - (DEB + 4)));
    wait_step(200, n);
    check("period_l1", n, 32);

    // Table of single presses from reset
    do_reset();
    for (int v = 0; v < 13; v++) begin
      press(tbl[v].keys, DEB + 4, chg);
      idle(DEB + 6);
      check($sformatf("tbl%0d_chg", v), chg, tbl[v].exp_chg);
      check($sformatf("tbl%0d_level", v), int'(speed_level), tbl[v].exp_level);
      check($sformatf("tbl%0d_paused", v), int'(paused), tbl[v].exp_paused);
      if (tbl[v].exp_period > 0) begin
        wait_step(200, n);
        wait_step(200, n);
        check($sformatf("tbl%0d_period", v), n, tbl[v].exp_period);
      end else begin
        count_steps(80, cnt);
        check($sformatf("tbl%0d_paused_steps", v), cnt, 0);
      end
    end

    // Pause lands on edge 10 (counter 10), resume continues from 10
    do_reset();
    idle(2);
    press(3'b100, DEB + 4, chg);
    check("pause_latency", chg, DEB + 4);
    check("pause_on", int'(paused), 1);
    count_steps(80, cnt);
    check("pause_no_steps", cnt, 0);
    press(3'b100, DEB + 4, chg);
    check("resume_latency", chg, DEB + 4);
    check("pause_off", int'(paused), 0);
    wait_step(200, n);
    check("resume_first_step", n, 53);
    wait_step(200, n);
    check("resume_period", n, 64);

    // Up and down together: no level change, no counter restart
    do_reset();
    press(3'b001, DEB + 4, chg);
    idle(DEB + 6);
    wait_step(200, n);
    {key_pause, key_down, key_up} = 3'b011;
    wait_step(200, n);
    check("updown_no_clear", n, 32);
    idle(20);
    check("updown_level", int'(speed_level), 1);
    {key_pause, key_down, key_up} = 3'b000;
    idle(DEB + 6);

    // Asynchronous reset between edges at level 2, paused
    do_reset();
    press(3'b001, DEB + 4, chg);
    idle(DEB + 6);
    press(3'b001, DEB + 4, chg);
    idle(DEB + 6);
    press(3'b100, DEB + 4, chg);
    idle(DEB + 6);
    check("pre_arst_level", int'(speed_level), 2);
    check("pre_arst_paused", int'(paused), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_step", int'(step), 0);
    check("arst_level", int'(speed_level), 0);
    check("arst_paused", int'(paused), 0);
    idle(2);
    #2 reset = 1'b0;
    wait_step(200, n);
    check("arst_first_step", n, 63);
    wait_step(200, n);
    check("arst_period", n, 64);

    // Key held through reset release counts as a fresh press
    reset  = 1'b1;
    key_up = 1'b1;
    idle(2);
    reset = 1'b0;
    press(3'b001, DEB + 8, chg);
    check("held_through_reset_latency", chg, DEB + 4);
    check("held_through_reset_level", int'(speed_level), 1);
    idle(DEB + 6);

    // Random key activity against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) key_up = ~key_up;
      if ($urandom_range(0, 15) == 0) key_down = ~key_down;
      if ($urandom_range(0, 15) == 0) key_pause = ~key_pause;
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b1;
        tick();
        #2 reset = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
